g11620_line_acc: RTL

//  Downstream pixel-capture stage for the G11620 sensor controller. Samples one
//  ADC word per clk for PIX_NUM+1 pixels after each ad_sp pulse, and accumulates

---
 rtl/g11620_line_acc_if.sv | 13 +
 rtl/g11620_line_acc.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/g11620_line_acc_if.sv
// Valid/ready stream of accumulated pixel words from the line accumulator.
// m_last marks the beat carrying the final pixel of the line.
interface g11620_line_acc_if #(
  parameter int unsigned ACC_W = 32
);
  logic [ACC_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/g11620_line_acc.sv
// Line accumulator: sums FRAMES sensor lines per pixel into a 512-entry buffer, then streams it.
// Build option G11620_ACC_SAT_EN: clamp overflowing sums to all-ones instead of wrapping.
module g11620_line_acc #(
  parameter logic [8:0]  PIX_NUM = 9'd511,
  parameter int unsigned ADC_W   = 16,
  parameter int unsigned ACC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              soft_reset_in,
  input  logic [15:0]       frames_in,
  input  logic              ad_sp,
  input  logic [ADC_W-1:0]  adc_data,
  g11620_line_acc_if.master m_if,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o
);
  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = 9;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SP, S_CAPTURE, S_READOUT} state_t;

  state_t           state_q;
  logic             start_q;
  logic [15:0]      frames_q, frame_cnt_q;
  logic [AW-1:0]    pix_cnt_q, rd_ptr_q, wr_addr_q;
  logic             rd_done_q;
  logic             wr_en_q, wr_first_q;
  logic [ACC_W-1:0] wr_val_q;
  logic             pipe_vld_q, pipe_last_q;
  logic             sk_vld_q, sk_last_q;
  logic [ACC_W-1:0] sk_data_q;
  logic             m_valid_q, m_last_q;
  logic [ACC_W-1:0] m_data_q;
  logic             busy_q, done_q, ovf_q;
  logic [ACC_W-1:0] mem [DEPTH];
  logic [ACC_W-1:0] rd_q;

  logic             start_edge_c, carry_c, rd_issue_c, pop_c;
  logic [ACC_W:0]   sum_c;
  logic [ACC_W-1:0] wr_data_c;
  logic [AW-1:0]    raddr_c;

  // Write-back value of the read-modify-write pipeline and readout issue control
  always_comb begin
    start_edge_c = start_in & ~start_q;
    sum_c        = {1'b0, rd_q} + {1'b0, wr_val_q};
    carry_c      = ~wr_first_q & sum_c[ACC_W];
    wr_data_c    = wr_first_q ? wr_val_q : sum_c[ACC_W-1:0];
`ifdef G11620_ACC_SAT_EN
    if (carry_c) wr_data_c = {ACC_W{1'b1}};
`endif
    pop_c        = m_valid_q & m_if.m_ready;
    // A new read may only be issued if its data is guaranteed a slot next cycle
    rd_issue_c   = (state_q == S_READOUT) & ~rd_done_q & ~sk_vld_q
                   & ~(pipe_vld_q & m_valid_q & ~m_if.m_ready);
    raddr_c      = (state_q == S_CAPTURE) ? pix_cnt_q : rd_ptr_q;
  end

  // Buffer RAM with write-to-read bypass so a same-cycle write is never missed
  always_ff @(posedge clk) begin
    if (wr_en_q) mem[wr_addr_q] <= wr_data_c;
    rd_q <= (wr_en_q && (wr_addr_q == raddr_c)) ? wr_data_c : mem[raddr_c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      frames_q    <= '0;
      frame_cnt_q <= '0;
      pix_cnt_q   <= '0;
      rd_ptr_q    <= '0;
      wr_addr_q   <= '0;
      rd_done_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_first_q  <= 1'b0;
      wr_val_q    <= '0;
      pipe_vld_q  <= 1'b0;
      pipe_last_q <= 1'b0;
      sk_vld_q    <= 1'b0;
      sk_last_q   <= 1'b0;
      sk_data_q   <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      start_q     <= start_in;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      pipe_vld_q  <= rd_issue_c;
      pipe_last_q <= rd_issue_c && (rd_ptr_q == PIX_NUM);
      if (wr_en_q && carry_c) ovf_q <= 1'b1;

      // Output register backed by a one-entry skid buffer
      if (!m_valid_q || pop_c) begin
        if (sk_vld_q) begin
          m_valid_q <= 1'b1;
          m_data_q  <= sk_data_q;
          m_last_q  <= sk_last_q;
          sk_vld_q  <= pipe_vld_q;
          sk_data_q <= rd_q;
          sk_last_q <= pipe_last_q;
        end else begin
          m_valid_q <= pipe_vld_q;
          m_data_q  <= rd_q;
          m_last_q  <= pipe_vld_q & pipe_last_q;
        end
      end else if (pipe_vld_q) begin
        sk_vld_q  <= 1'b1;
        sk_data_q <= rd_q;
        sk_last_q <= pipe_last_q;
      end

      if (rd_issue_c) begin
        rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
        if (rd_ptr_q == PIX_NUM) rd_done_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start_edge_c) begin
            frames_q    <= (frames_in == 16'd0) ? 16'd1 : frames_in;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_WAIT_SP;
          end
        end
        S_WAIT_SP: begin
          if (ad_sp) begin
            pix_cnt_q <= '0;
            state_q   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          wr_en_q    <= 1'b1;
          wr_addr_q  <= pix_cnt_q;
          wr_val_q   <= ACC_W'(adc_data);
          wr_first_q <= (frame_cnt_q == 16'd0);
          pix_cnt_q  <= AW'(pix_cnt_q + 1'b1);
          if (pix_cnt_q == PIX_NUM) begin
            frame_cnt_q <= 16'(frame_cnt_q + 16'd1);
            if (16'(frame_cnt_q + 16'd1) == frames_q) begin
              rd_ptr_q  <= '0;
              rd_done_q <= 1'b0;
              state_q   <= S_READOUT;
            end else begin
              state_q   <= S_WAIT_SP;
            end
          end
        end
        S_READOUT: begin
          if (pop_c && m_last_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Abort wins over every other update this cycle
      if (soft_reset_in) begin
        state_q    <= S_IDLE;
        busy_q     <= 1'b0;
        done_q     <= 1'b0;
        m_valid_q  <= 1'b0;
        m_last_q   <= 1'b0;
        sk_vld_q   <= 1'b0;
        pipe_vld_q <= 1'b0;
        wr_en_q    <= 1'b0;
      end
    end
  end

  assign m_if.m_data  = m_data_q;
  assign m_if.m_valid = m_valid_q;
  assign m_if.m_last  = m_last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign ovf_o        = ovf_q;
endmodule
